// File: rtl/pcs_pkg.sv
// Shared XGMII constants, scheduler state encoding and frame-delimiter helpers
// for the MAC-to-PCS transmit path.
package pcs_pkg;

    localparam int XGMII_DATA_WIDTH = 32;
    localparam int XGMII_CTRL_WIDTH = 4;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        HIGH   = 2'd1,
        ERR_HI = 2'd2
    } tx_sched_state_t;

    // A frame may only start on lane 0 of a word.
    function automatic logic has_start(input logic [63:0] data, input logic [7:0] ctrl);
        return ctrl[0] && (data[7:0] == XGMII_START);
    endfunction

    function automatic logic has_term(input logic [63:0] data, input logic [7:0] ctrl);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (ctrl[k] && (data[8*k +: 8] == XGMII_TERM)) begin
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/xgmii_tx_scheduler_if.sv
// MAC-side word stream: one 64-bit word plus per-lane control flags per handshake.
interface xgmii_tx_scheduler_if;
    logic [63:0] s_data;
    logic [7:0]  s_ctrl;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_ctrl, output s_valid, input s_ready);
    modport slave  (input s_data, input s_ctrl, input s_valid, output s_ready);
endinterface

// File: rtl/xgmii_word_fifo.sv
// Word FIFO between the MAC and the scheduler; an entry becomes readable on the
// cycle after it was written, and ready/level come straight from registers.
module xgmii_word_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic [71:0]                   i_wdata,
    input  logic                          i_pop,
    output logic [71:0]                   o_rdata,
    output logic                          o_avail,
    output logic                          o_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [71:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_pushed;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_n;

    // The word written last cycle is not yet visible at the head.
    assign o_avail   = (r_level != {{AW{1'b0}}, r_pushed});
    assign w_push    = i_push && r_ready;
    assign w_pop     = i_pop && o_avail;
    assign w_level_n = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    assign o_rdata   = r_mem[r_rptr];
    assign o_ready   = r_ready;
    assign o_level   = r_level;

    // Pointer, occupancy and ready registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr   <= {AW{1'b0}};
            r_rptr   <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
            r_pushed <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_wptr   <= r_wptr + {{(AW-1){1'b0}}, w_push};
            r_rptr   <= r_rptr + {{(AW-1){1'b0}}, w_pop};
            r_level  <= w_level_n;
            r_pushed <= w_push;
            r_ready  <= (w_level_n != LW'(FIFO_DEPTH));
        end
    end

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/xgmii_tx_scheduler.sv
// Splits buffered 64-bit MAC words into low/high 32-bit XGMII beats, stalls on
// PCS pause, fills gaps with idles and closes starved frames with an /E/ pair.
module xgmii_tx_scheduler
    import pcs_pkg::*;
#(
    parameter int DATA_WIDTH = XGMII_DATA_WIDTH,
    parameter int CTRL_WIDTH = XGMII_CTRL_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    xgmii_tx_scheduler_if.slave           s_if,
    output logic [DATA_WIDTH-1:0]         o_xgmii_txd,
    output logic [CTRL_WIDTH-1:0]         o_xgmii_txc,
    output logic                          o_xgmii_valid,
    input  logic                          i_xgmii_pause,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    tx_sched_state_t       r_state;
    tx_sched_state_t       w_state_n;
    logic [DATA_WIDTH-1:0] r_txd;
    logic [DATA_WIDTH-1:0] w_txd_n;
    logic [CTRL_WIDTH-1:0] r_txc;
    logic [CTRL_WIDTH-1:0] w_txc_n;
    logic                  r_valid;
    logic                  w_valid_n;
    logic                  r_underflow;
    logic                  w_underflow_n;
    logic                  r_in_frame;
    logic                  w_in_frame_n;
    logic                  r_discard;
    logic                  w_discard_n;
    logic                  w_pop;
    logic                  w_avail;
    logic [71:0]           w_head;
    logic                  w_start;
    logic                  w_term;

    xgmii_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (s_if.s_valid),
        .i_wdata ({s_if.s_ctrl, s_if.s_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_avail (w_avail),
        .o_ready (s_if.s_ready),
        .o_level (o_fifo_level)
    );

    assign w_start = has_start(w_head[63:0], w_head[71:64]);
    assign w_term  = has_term(w_head[63:0], w_head[71:64]);

    // Next beat selection; a pause freezes everything except valid.
    always_comb begin
        w_state_n     = r_state;
        w_txd_n       = r_txd;
        w_txc_n       = r_txc;
        w_valid_n     = 1'b0;
        w_underflow_n = 1'b0;
        w_pop         = 1'b0;
        w_in_frame_n  = r_in_frame;
        w_discard_n   = r_discard;
        if (i_xgmii_pause) begin
            w_valid_n = 1'b0;
        end else begin
            w_valid_n = 1'b1;
            case (r_state)
                LOW: begin
                    if (!w_avail) begin
                        if (r_in_frame) begin
                            w_txd_n       = {4{XGMII_ERROR}};
                            w_txc_n       = {CTRL_WIDTH{1'b1}};
                            w_state_n     = ERR_HI;
                            w_underflow_n = 1'b1;
                            w_discard_n   = 1'b1;
                        end else begin
                            w_txd_n = {4{XGMII_IDLE}};
                            w_txc_n = {CTRL_WIDTH{1'b1}};
                        end
                    end else if (r_discard && !w_start) begin
                        // Remnant of an aborted frame: drop it, leave on its terminator.
                        w_pop       = 1'b1;
                        w_txd_n     = {4{XGMII_IDLE}};
                        w_txc_n     = {CTRL_WIDTH{1'b1}};
                        w_discard_n = !w_term;
                    end else begin
                        w_txd_n     = w_head[31:0];
                        w_txc_n     = w_head[67:64];
                        w_state_n   = HIGH;
                        w_discard_n = 1'b0;
                    end
                end
                HIGH: begin
                    w_txd_n      = w_head[63:32];
                    w_txc_n      = w_head[71:68];
                    w_pop        = 1'b1;
                    w_state_n    = LOW;
                    w_in_frame_n = (r_in_frame || w_start) && !w_term;
                end
                ERR_HI: begin
                    w_txd_n      = {4{XGMII_ERROR}};
                    w_txc_n      = {CTRL_WIDTH{1'b1}};
                    w_in_frame_n = 1'b0;
                    w_state_n    = LOW;
                end
                default: begin
                    w_txd_n   = {4{XGMII_IDLE}};
                    w_txc_n   = {CTRL_WIDTH{1'b1}};
                    w_state_n = LOW;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= LOW;
            r_txd       <= {4{XGMII_IDLE}};
            r_txc       <= {CTRL_WIDTH{1'b1}};
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
            r_in_frame  <= 1'b0;
            r_discard   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_txd       <= w_txd_n;
            r_txc       <= w_txc_n;
            r_valid     <= w_valid_n;
            r_underflow <= w_underflow_n;
            r_in_frame  <= w_in_frame_n;
            r_discard   <= w_discard_n;
        end
    end

    assign o_xgmii_txd   = r_txd;
    assign o_xgmii_txc   = r_txc;
    assign o_xgmii_valid = r_valid;
    assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Directed, table-driven bench for xgmii_tx_scheduler with hand-computed beats.
module tb_xgmii_tx_scheduler;

    localparam logic [31:0] IDLE = 32'h07070707;
    localparam logic [31:0] ERRW = 32'hFEFEFEFE;
    localparam logic [63:0] W_SGL = 64'h1122334455667788;
    localparam logic [63:0] W_SOF = 64'hD5555555555555FB;
    localparam logic [63:0] W_EOF = 64'h07070707070707FD;
    localparam logic [63:0] W_DAT = 64'h0102030405060708;
    localparam logic [63:0] W_AFT = 64'hA1A2A3A4B1B2B3B4;

    typedef struct {
        logic        pause;
        logic        push;
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        e_valid;
        logic [31:0] e_txd;
        logic [3:0]  e_txc;
        logic        e_uf;
        logic [2:0]  e_level;
    } vec_t;

    logic        clk;
    logic        i_reset;
    logic        i_xgmii_pause;
    logic [31:0] o_xgmii_txd;
    logic [3:0]  o_xgmii_txc;
    logic        o_xgmii_valid;
    logic        o_underflow;
    logic [2:0]  o_fifo_level;

    int n_checks;
    int n_fail;

    xgmii_tx_scheduler_if s_if ();

    xgmii_tx_scheduler #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .FIFO_DEPTH(4)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .s_if          (s_if),
        .o_xgmii_txd   (o_xgmii_txd),
        .o_xgmii_txc   (o_xgmii_txc),
        .o_xgmii_valid (o_xgmii_valid),
        .i_xgmii_pause (i_xgmii_pause),
        .o_underflow   (o_underflow),
        .o_fifo_level  (o_fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mv(input logic p, input logic v, input logic [63:0] d,
                                input logic [7:0] c, input logic ev, input logic [31:0] et,
                                input logic [3:0] ec, input logic eu, input logic [2:0] el);
        vec_t r;
        r.pause = p; r.push = v; r.data = d; r.ctrl = c;
        r.e_valid = ev; r.e_txd = et; r.e_txc = ec; r.e_uf = eu; r.e_level = el;
        return r;
    endfunction

    task automatic cyc(input logic p, input logic v, input logic [63:0] d, input logic [7:0] c);
        i_xgmii_pause = p;
        s_if.s_valid  = v;
        s_if.s_data   = d;
        s_if.s_ctrl   = c;
        @(posedge clk);
        #1;
        s_if.s_valid  = 1'b0;
    endtask

    task automatic chk(input string nm, input logic ev, input logic [31:0] et,
                       input logic [3:0] ec, input logic eu, input logic [2:0] el);
        n_checks++;
        if (o_xgmii_valid !== ev || o_xgmii_txd !== et || o_xgmii_txc !== ec ||
            o_underflow !== eu || o_fifo_level !== el) begin
            n_fail++;
            $display("FAIL %s: got v=%0b txd=%h txc=%h uf=%0b lvl=%0d, want v=%0b txd=%h txc=%h uf=%0b lvl=%0d",
                     nm, o_xgmii_valid, o_xgmii_txd, o_xgmii_txc, o_underflow, o_fifo_level,
                     ev, et, ec, eu, el);
        end
    endtask

    task automatic chk_val(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    vec_t vecs [15];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // single word, then an FB/FD frame with one pause between halves, then a paused idle
        vecs[0]  = mv(1'b0, 1'b1, W_SGL, 8'h00, 1'b1, IDLE,         4'hF, 1'b0, 3'd1);
        vecs[1]  = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, IDLE,         4'hF, 1'b0, 3'd1);
        vecs[2]  = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 32'h55667788, 4'h0, 1'b0, 3'd1);
        vecs[3]  = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 32'h11223344, 4'h0, 1'b0, 3'd0);
        vecs[4]  = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, IDLE,         4'hF, 1'b0, 3'd0);
        vecs[5]  = mv(1'b0, 1'b1, W_SOF, 8'h01, 1'b1, IDLE,         4'hF, 1'b0, 3'd1);
        vecs[6]  = mv(1'b0, 1'b1, W_EOF, 8'hFF, 1'b1, IDLE,         4'hF, 1'b0, 3'd2);
        vecs[7]  = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 32'h555555FB, 4'h1, 1'b0, 3'd2);
        vecs[8]  = mv(1'b1, 1'b0, 64'd0, 8'h00, 1'b0, 32'h555555FB, 4'h1, 1'b0, 3'd2);
        vecs[9]  = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 32'hD5555555, 4'h0, 1'b0, 3'd1);
        vecs[10] = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 32'h070707FD, 4'hF, 1'b0, 3'd1);
        vecs[11] = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, IDLE,         4'hF, 1'b0, 3'd0);
        vecs[12] = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, IDLE,         4'hF, 1'b0, 3'd0);
        vecs[13] = mv(1'b1, 1'b0, 64'd0, 8'h00, 1'b0, IDLE,         4'hF, 1'b0, 3'd0);
        vecs[14] = mv(1'b0, 1'b0, 64'd0, 8'h00, 1'b1, IDLE,         4'hF, 1'b0, 3'd0);
        // the high half of W_EOF is 07070707/F, indistinguishable from idle on the wire

        i_reset       = 1'b1;
        i_xgmii_pause = 1'b0;
        s_if.s_valid  = 1'b0;
        s_if.s_data   = 64'd0;
        s_if.s_ctrl   = 8'h00;
        cyc(1'b0, 1'b0, 64'd0, 8'h00);
        cyc(1'b0, 1'b0, 64'd0, 8'h00);
        chk("reset_state", 1'b0, IDLE, 4'hF, 1'b0, 3'd0);
        chk_val("reset_ready", int'(s_if.s_ready), 0);

        i_reset = 1'b0;
        cyc(1'b0, 1'b0, 64'd0, 8'h00);
        chk_val("ready_after_reset", int'(s_if.s_ready), 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 64'd0, 8'h00);
            chk($sformatf("idle%0d", i), 1'b1, IDLE, 4'hF, 1'b0, 3'd0);
            chk_val($sformatf("idle_ready%0d", i), int'(s_if.s_ready), 1);
        end

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].pause, vecs[i].push, vecs[i].data, vecs[i].ctrl);
            chk($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_txd, vecs[i].e_txc,
                vecs[i].e_uf, vecs[i].e_level);
        end

        // starved frame: /E/ pair, then a late terminator word is dropped
        cyc(1'b0, 1'b1, W_SOF, 8'h01); chk("uf_push0", 1'b1, IDLE, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, W_DAT, 8'h00); chk("uf_push1", 1'b1, IDLE, 4'hF, 1'b0, 3'd2);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("uf_lo0", 1'b1, 32'h555555FB, 4'h1, 1'b0, 3'd2);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("uf_hi0", 1'b1, 32'hD5555555, 4'h0, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("uf_lo1", 1'b1, 32'h05060708, 4'h0, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("uf_hi1", 1'b1, 32'h01020304, 4'h0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("uf_err0", 1'b1, ERRW, 4'hF, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("uf_err1", 1'b1, ERRW, 4'hF, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("uf_idle", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, W_EOF, 8'hFF); chk("late_push", 1'b1, IDLE, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("late_wait", 1'b1, IDLE, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("late_drop", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("late_idle", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, W_AFT, 8'h00); chk("after_push", 1'b1, IDLE, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("after_wait", 1'b1, IDLE, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("after_lo", 1'b1, 32'hB1B2B3B4, 4'h0, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("after_hi", 1'b1, 32'hA1A2A3A4, 4'h0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("after_idle", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);

        // backpressure: 10 paused cycles while offering 6 words, then drain in order
        begin
            logic [63:0] bp [6];
            int idx;
            int nbeat;
            logic acc;
            for (int k = 0; k < 6; k++) begin
                bp[k] = {32'hB0000000 | 32'(2*k + 1), 32'hB0000000 | 32'(2*k)};
            end
            idx = 0;
            nbeat = 0;
            i_xgmii_pause = 1'b1;
            for (int c = 0; c < 10; c++) begin
                s_if.s_valid = (idx < 6);
                s_if.s_data  = (idx < 6) ? bp[idx] : 64'd0;
                s_if.s_ctrl  = 8'h00;
                acc = s_if.s_valid && s_if.s_ready;
                @(posedge clk);
                #1;
                if (acc) idx++;
            end
            chk("bp_full", 1'b0, IDLE, 4'hF, 1'b0, 3'd4);
            chk_val("bp_ready_low", int'(s_if.s_ready), 0);
            chk_val("bp_accepted_while_paused", idx, 4);
            i_xgmii_pause = 1'b0;
            for (int c = 0; c < 60 && nbeat < 12; c++) begin
                s_if.s_valid = (idx < 6);
                s_if.s_data  = (idx < 6) ? bp[idx] : 64'd0;
                acc = s_if.s_valid && s_if.s_ready;
                @(posedge clk);
                #1;
                if (acc) idx++;
                if (o_xgmii_valid && o_xgmii_txc == 4'h0) begin
                    chk_val($sformatf("bp_beat%0d", nbeat), int'(o_xgmii_txd),
                            int'(32'hB0000000 | 32'(nbeat)));
                    nbeat++;
                end
            end
            s_if.s_valid = 1'b0;
            chk_val("bp_beat_count", nbeat, 12);
            chk_val("bp_words_accepted", idx, 6);
        end
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("bp_idle", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);

        // reset during a high beat flushes the frame without /E/
        cyc(1'b0, 1'b1, W_SOF, 8'h01); chk("rst_push0", 1'b1, IDLE, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, W_DAT, 8'h00); chk("rst_push1", 1'b1, IDLE, 4'hF, 1'b0, 3'd2);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("rst_lo0", 1'b1, 32'h555555FB, 4'h1, 1'b0, 3'd2);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("rst_hi0", 1'b1, 32'hD5555555, 4'h0, 1'b0, 3'd1);
        i_reset = 1'b1;
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("rst_mid", 1'b0, IDLE, 4'hF, 1'b0, 3'd0);
        chk_val("rst_mid_ready", int'(s_if.s_ready), 0);
        i_reset = 1'b0;
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("rst_rel", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);
        chk_val("rst_rel_ready", int'(s_if.s_ready), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 64'd0, 8'h00);
            chk($sformatf("rst_no_err%0d", i), 1'b1, IDLE, 4'hF, 1'b0, 3'd0);
        end
        cyc(1'b0, 1'b1, W_SOF, 8'h01); chk("nf_push0", 1'b1, IDLE, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, W_EOF, 8'hFF); chk("nf_push1", 1'b1, IDLE, 4'hF, 1'b0, 3'd2);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("nf_lo0", 1'b1, 32'h555555FB, 4'h1, 1'b0, 3'd2);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("nf_hi0", 1'b1, 32'hD5555555, 4'h0, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("nf_lo1", 1'b1, 32'h070707FD, 4'hF, 1'b0, 3'd1);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("nf_hi1", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 64'd0, 8'h00); chk("nf_idle", 1'b1, IDLE, 4'hF, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xgmii_tx_scheduler.md
Name: xgmii_tx_scheduler

Overview:
- Sequences 64-bit MAC words onto the 32-bit XGMII TX interface of the PCS as two beats per word, low half first.
- Honours the PCS gearbox pause: each pause costs one stalled beat and drops no data.
- Inserts XGMII idles when no data is queued.
- Turns a mid-frame starvation into a clean /E/-terminated error. Sits between the MAC TX path and the PCS TX XGMII input.

Parameters:
- DATA_WIDTH, 32, XGMII beat data width.
- CTRL_WIDTH, 4, XGMII beat control width.
- FIFO_DEPTH, 4, number of 64-bit words buffered; power of 2, at least 2.

Ports:
- i_clk  in  1  single clock for the block.
- i_reset  in  1  synchronous, active-high reset.
- s_data  in  64  MAC word; lane k is bits [8k+7:8k].
- s_ctrl  in  8  MAC control; bit k flags lane k.
- s_valid  in  1  MAC word valid.
- s_ready  out  1  word accepted when s_valid and s_ready are both 1.
- o_xgmii_txd  out  32  beat data to the PCS.
- o_xgmii_txc  out  4  beat control to the PCS.
- o_xgmii_valid  out  1  beat valid to the PCS.
- i_xgmii_pause  in  1  PCS gearbox pause.
- o_underflow  out  1  one-cycle pulse when an /E/ pair is inserted.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock (i_clk). Reset (i_reset) is synchronous and active-high.
- Reset values:
  - o_xgmii_valid=0, o_xgmii_txd=32'h07070707, o_xgmii_txc=4'hF.
  - o_underflow=0, o_fifo_level=0, s_ready=0.
  - FSM in LOW, in_frame=0, discard=0.
  - s_ready goes to 1 on the first cycle after reset deasserts.
  - Reset mid-frame flushes the FIFO. No /E/ is emitted.
- Input side:
  - s_ready = (level != FIFO_DEPTH), driven from a registered count.
  - No bypass: a push and pop in the same cycle are both legal unless the FIFO is full.
  - Level updates on the edge after the event.
- Output registers: all outputs are registered. At each rising edge:
  - If i_xgmii_pause=1: load o_xgmii_valid=0; txd, txc and FSM state hold.
  - Else: load the next beat with o_xgmii_valid=1.
  - The PCS raises pause one cycle ahead of its slip cycle, so the stalled beat lines up with the slip.
- FSM states:
  - LOW: emit head[31:0] / ctrl[3:0] → HIGH.
    - If the FIFO is empty and in_frame=0: emit idle (07070707 / F) and stay in LOW.
    - If the FIFO is empty and in_frame=1: emit FEFEFEFE / F → ERR_HI, pulse o_underflow, set discard=1.
  - HIGH: emit head[63:32] / ctrl[7:4], pop the head → LOW.
  - ERR_HI: emit FEFEFEFE / F, clear in_frame → LOW.
- Word integrity: a word's two halves are always consecutive valid beats. Only pause-stall cycles may separate them.
- Frame tracking, evaluated at pop:
  - Lane 0 with ctrl=1 and data=FB sets in_frame.
  - Any lane with ctrl=1 and data=FD clears in_frame.
- Discard mode:
  - While discard=1, popped words are dropped and nothing is emitted for them; idles are sent instead.
  - The word containing FD is dropped too and clears discard.
  - A word with FB seen while discard=1 clears discard and is transmitted normally.
- Latency: a word pushed at edge N into an empty FIFO, with no pause, drives its low beat after edge N+2 and its high beat after edge N+3.
- Back-to-back pauses: each pause cycle adds one stall. A pause held continuously keeps valid=0 indefinitely with no state change.

Decomposition:
- Package pcs_pkg:
  - XGMII_IDLE=8'h07, XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_ERROR=8'hFE.
  - DATA_WIDTH/CTRL_WIDTH constants.
  - FSM enum tx_sched_state_t {LOW, HIGH, ERR_HI}.
- Sub-module xgmii_word_fifo: synchronous FIFO, 72 bits wide, FIFO_DEPTH deep, with level output. The scheduler holds the FSM and the output registers.

Test Plan:
- Idle after reset: no s_valid for 20 cycles → every beat is 07070707/F with valid=1; o_fifo_level=0; s_ready=1.
- Single word: push data=0x1122334455667788, ctrl=0x00 with no pause → beat 55667788/0 then beat 11223344/0 on consecutive cycles, 2 cycles after the push edge, then idles.
- Pause between halves: push frame FB-start word then FD-terminated word; assert pause for 1 cycle after the first low beat → exactly one valid=0 cycle, then the high beat. Sequence is unchanged and the beat count equals 4.
- Backpressure: hold pause for 10 cycles while pushing 6 words → s_ready drops after level=4 and all 6 words emerge in order. No word is lost or duplicated.
- Underflow: push FB start word plus one data word, then stop → after the 4 data beats, FEFEFEFE/F twice, o_underflow pulses once, then idles. A late FD word is silently dropped.
- Reset mid-frame: assert i_reset for 1 cycle during a high beat → next output is idle with valid=0, level=0, no /E/ emitted. The following frame is transmitted intact.
